// File: rtl/mig_arb_pkg.sv
// Shared types and MIG command encodings for the MIG application-port arbiter.
package mig_arb_pkg;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_WR,
        S_RD
    } arb_state_e;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

endpackage

// File: rtl/mig_rd_tracker.sv
// Outstanding-read counter, sticky underflow flag and one-cycle read-data register.
module mig_rd_tracker #(
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned MAX_RD_OUT = 16
) (
    input  logic              ui_clk,
    input  logic              ui_clk_sync_rst,
    input  logic              rd_accept,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_underflow_err,
    output logic              rd_full,
    output logic              rd_pending
);

    localparam int unsigned CntW = $clog2(MAX_RD_OUT) + 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = rd_underflow_err;
        if (rd_accept && !app_rd_data_valid) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!rd_accept && app_rd_data_valid) begin
            // A return with nothing outstanding is a MIG/protocol fault; keep count at zero.
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            cnt_q            <= '0;
            rd_underflow_err <= 1'b0;
            rd_data          <= '0;
            rd_valid         <= 1'b0;
        end else begin
            cnt_q            <= cnt_d;
            rd_underflow_err <= err_d;
            rd_data          <= app_rd_data;
            rd_valid         <= app_rd_data_valid;
        end
    end

    assign rd_full    = (cnt_q == CntW'(MAX_RD_OUT));
    assign rd_pending = (cnt_q != '0);

endmodule

// File: rtl/mig_app_arbiter.sv
// Two-requester (write/read) arbiter onto a MIG 7-series application port.
// Define MIG_ARB_RD_PRIORITY_EN to make an eligible read always win over a write.
module mig_app_arbiter
    import mig_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 29,
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned MAX_RD_OUT = 16
) (
    input  logic              ui_clk,
    input  logic              ui_clk_sync_rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    input  logic              init_calib_complete,
    output logic              rd_underflow_err,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rr_wr_q, rr_wr_d;  // 1: write wins the next tie
    logic              rd_full, rd_pending;
    logic              rd_elig, grant_rd, grant_wr;
    logic              unused_addr_lsb;

    assign rd_elig = rd_req && !rd_full;
`ifdef MIG_ARB_RD_PRIORITY_EN
    assign grant_rd = rd_elig;
`else
    assign grant_rd = rd_elig && (!wr_req || !rr_wr_q);
`endif
    assign grant_wr = wr_req && !grant_rd;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rr_wr_d      = rr_wr_q;
        app_en       = 1'b0;
        app_wdf_wren = 1'b0;
        app_cmd      = CMD_WRITE;
        wr_ack       = 1'b0;
        rd_ack       = 1'b0;
        unique case (state_q)
            S_INIT: begin
                if (init_calib_complete) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!init_calib_complete) begin
                    state_d = S_INIT;
                end else if (grant_wr) begin
                    state_d = S_WR;
                    addr_d  = wr_addr;
                    data_d  = wr_data;
                    rr_wr_d = 1'b0;
                end else if (grant_rd) begin
                    state_d = S_RD;
                    addr_d  = rd_addr;
                    rr_wr_d = 1'b1;
                end
            end
            S_WR: begin
                app_en       = 1'b1;
                app_wdf_wren = 1'b1;
                if (app_rdy && app_wdf_rdy) begin
                    wr_ack  = 1'b1;
                    state_d = init_calib_complete ? S_IDLE : S_INIT;
                end
            end
            S_RD: begin
                app_en  = 1'b1;
                app_cmd = CMD_READ;
                if (app_rdy) begin
                    rd_ack  = 1'b1;
                    state_d = init_calib_complete ? S_IDLE : S_INIT;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            state_q <= S_INIT;
            addr_q  <= '0;
            data_q  <= '0;
            rr_wr_q <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rr_wr_q <= rr_wr_d;
        end
    end

    // Commands are issued on 8-address burst boundaries.
    assign app_addr        = {addr_q[ADDR_W-1:3], 3'b000};
    assign unused_addr_lsb = ^addr_q[2:0];
    assign app_wdf_data    = data_q;
    assign app_wdf_end     = app_wdf_wren;
    assign busy            = (state_q != S_IDLE) || rd_pending;

    mig_rd_tracker #(
        .DATA_W     (DATA_W),
        .MAX_RD_OUT (MAX_RD_OUT)
    ) u_rd_tracker (
        .ui_clk            (ui_clk),
        .ui_clk_sync_rst   (ui_clk_sync_rst),
        .rd_accept         (rd_ack),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid),
        .rd_underflow_err  (rd_underflow_err),
        .rd_full           (rd_full),
        .rd_pending        (rd_pending)
    );

endmodule

// File: tb/tb_mig_app_arbiter.sv
// Self-checking bench for mig_app_arbiter: directed scenarios plus a randomized run,
// all compared every cycle against a transaction-level model.
module tb_mig_app_arbiter;

    localparam int ADDR_W     = 29;
    localparam int DATA_W     = 256;
    localparam int MAX_RD_OUT = 16;

    logic              ui_clk;
    logic              ui_clk_sync_rst;
    logic              wr_req, rd_req;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack, rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic [DATA_W-1:0] app_wdf_data;
    logic              app_wdf_wren, app_wdf_end;
    logic              app_rdy, app_wdf_rdy;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_rd_data_valid;
    logic              init_calib_complete;
    logic              rd_underflow_err, busy;

    mig_app_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_RD_OUT (MAX_RD_OUT)
    ) dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .wr_req              (wr_req),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data),
        .wr_ack              (wr_ack),
        .rd_req              (rd_req),
        .rd_addr             (rd_addr),
        .rd_ack              (rd_ack),
        .rd_data             (rd_data),
        .rd_valid            (rd_valid),
        .app_en              (app_en),
        .app_cmd             (app_cmd),
        .app_addr            (app_addr),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_rdy             (app_rdy),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .init_calib_complete (init_calib_complete),
        .rd_underflow_err    (rd_underflow_err),
        .busy                (busy)
    );

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: phase 0 = waiting calibration, 1 = free, 2 = write issued, 3 = read issued.
    int                m_phase;
    bit                m_wr_next;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    int                m_out;
    bit                m_err, m_rdv;
    logic [DATA_W-1:0] m_rdd;
    bit                e_wr_ack, e_rd_ack;

    bit                obs_en, obs_wr_ack, obs_rd_ack, obs_err, obs_busy;
    logic [ADDR_W-1:0] obs_addr;
    logic [DATA_W-1:0] obs_wdata;

    task automatic model_reset();
        m_phase = 0; m_wr_next = 1'b1; m_addr = '0; m_data = '0;
        m_out = 0; m_err = 1'b0; m_rdv = 1'b0; m_rdd = '0;
    endtask

    function automatic logic [DATA_W-1:0] rand256();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Inputs are set by the caller just after a falling edge; check, then advance the model.
    task automatic step();
        bit                e_en, e_wren, e_busy, elig, take_rd;
        logic [2:0]        e_cmd;
        logic [ADDR_W-1:0] e_addr;
        #1;
        e_en     = (m_phase == 2) || (m_phase == 3);
        e_wren   = (m_phase == 2);
        e_cmd    = (m_phase == 3) ? 3'b001 : 3'b000;
        e_addr   = m_addr & ~ADDR_W'(7);
        e_wr_ack = (m_phase == 2) && app_rdy && app_wdf_rdy;
        e_rd_ack = (m_phase == 3) && app_rdy;
        e_busy   = (m_phase != 1) || (m_out != 0);
        chk("app_en", DATA_W'(app_en), DATA_W'(e_en));
        chk("app_wdf_wren", DATA_W'(app_wdf_wren), DATA_W'(e_wren));
        chk("app_wdf_end", DATA_W'(app_wdf_end), DATA_W'(e_wren));
        chk("app_cmd", DATA_W'(app_cmd), DATA_W'(e_cmd));
        chk("app_addr", DATA_W'(app_addr), DATA_W'(e_addr));
        chk("app_wdf_data", app_wdf_data, m_data);
        chk("wr_ack", DATA_W'(wr_ack), DATA_W'(e_wr_ack));
        chk("rd_ack", DATA_W'(rd_ack), DATA_W'(e_rd_ack));
        chk("busy", DATA_W'(busy), DATA_W'(e_busy));
        chk("rd_underflow_err", DATA_W'(rd_underflow_err), DATA_W'(m_err));
        chk("rd_valid", DATA_W'(rd_valid), DATA_W'(m_rdv));
        chk("rd_data", rd_data, m_rdd);
        obs_en = app_en; obs_wr_ack = wr_ack; obs_rd_ack = rd_ack;
        obs_err = rd_underflow_err; obs_busy = busy;
        obs_addr = app_addr; obs_wdata = app_wdf_data;

        if (ui_clk_sync_rst) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (init_calib_complete) m_phase = 1;
                1: begin
                    if (!init_calib_complete) begin
                        m_phase = 0;
                    end else begin
                        elig = rd_req && (m_out < MAX_RD_OUT);
`ifdef MIG_ARB_RD_PRIORITY_EN
                        take_rd = elig;
`else
                        take_rd = elig && !(wr_req && m_wr_next);
`endif
                        if (take_rd) begin
                            m_phase = 3; m_addr = rd_addr; m_wr_next = 1'b1;
                        end else if (wr_req) begin
                            m_phase = 2; m_addr = wr_addr; m_data = wr_data; m_wr_next = 1'b0;
                        end
                    end
                end
                2: if (e_wr_ack) m_phase = init_calib_complete ? 1 : 0;
                3: if (e_rd_ack) m_phase = init_calib_complete ? 1 : 0;
                default: m_phase = 0;
            endcase
            if (app_rd_data_valid && !e_rd_ack) begin
                if (m_out == 0) m_err = 1'b1;
                else m_out--;
            end else if (e_rd_ack && !app_rd_data_valid) begin
                m_out++;
            end
            m_rdv = app_rd_data_valid;
            m_rdd = app_rd_data;
        end
        @(negedge ui_clk);
    endtask

    task automatic do_reset();
        ui_clk_sync_rst = 1'b1;
        step();
        step();
        ui_clk_sync_rst = 1'b0;
    endtask

    task automatic wait_en(input string name);
        int n = 0;
        while (!obs_en && n < 12) begin
            step();
            n++;
        end
        if (!obs_en) chk(name, DATA_W'(0), DATA_W'(1));
    endtask

    int                en_cnt, ack_cnt, mem_pend, calib_lo, nseq;
    bit                seen_en;
    logic [3:0]        seq;
    logic [DATA_W-1:0] dval;

    initial begin
        ui_clk_sync_rst = 1'b1;
        wr_req = 0; rd_req = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        app_rdy = 0; app_wdf_rdy = 0; app_rd_data = '0; app_rd_data_valid = 0;
        init_calib_complete = 0;
        model_reset();
        @(negedge ui_clk);
        step();
        step();
        chk("reset_app_en", DATA_W'(obs_en), DATA_W'(0));
        chk("reset_app_addr", DATA_W'(obs_addr), DATA_W'(0));
        chk("reset_busy", DATA_W'(obs_busy), DATA_W'(1));
        ui_clk_sync_rst = 1'b0;

        // Calibration hold-off, then the basic write.
        wr_req = 1; wr_addr = ADDR_W'('h10); wr_data = DATA_W'(2); app_rdy = 1; app_wdf_rdy = 1;
        seen_en = 0;
        repeat (100) begin
            step();
            if (obs_en) seen_en = 1;
        end
        chk("calib_blocks_en", DATA_W'(seen_en), DATA_W'(0));
        init_calib_complete = 1;
        step();
        step();
        chk("wr_not_before_grant", DATA_W'(obs_en), DATA_W'(0));
        step();
        chk("wr_en_cycle2", DATA_W'(obs_en), DATA_W'(1));
        chk("wr_ack_cycle2", DATA_W'(obs_wr_ack), DATA_W'(1));
        chk("wr_addr_0x10", DATA_W'(obs_addr), DATA_W'('h10));
        chk("wr_data_2", obs_wdata, DATA_W'(2));
        wr_req = 0;
        step();

        // Burst alignment of the issued address.
        wr_req = 1; wr_addr = ADDR_W'('h13); wr_data = rand256();
        wait_en("align_timeout");
        chk("addr_aligned", DATA_W'(obs_addr), DATA_W'('h10));
        wr_req = 0;
        step();

        // Write-data stall: address/data latched at grant, single ack.
        dval = rand256();
        wr_req = 1; wr_addr = ADDR_W'('h200); wr_data = dval; app_wdf_rdy = 0;
        wait_en("stall_timeout");
        en_cnt = obs_en ? 1 : 0;
        ack_cnt = 0;
        wr_data = ~dval;
        wr_addr = ADDR_W'('h5a8);
        repeat (4) begin
            step();
            en_cnt += obs_en; ack_cnt += obs_wr_ack;
        end
        app_wdf_rdy = 1;
        step();
        en_cnt += obs_en; ack_cnt += obs_wr_ack;
        chk("stall_data_latched", obs_wdata, dval);
        chk("stall_addr_latched", DATA_W'(obs_addr), DATA_W'('h200));
        wr_req = 0;
        step();
        en_cnt += obs_en; ack_cnt += obs_wr_ack;
        chk("stall_en_cycles", DATA_W'(en_cnt), DATA_W'(6));
        chk("stall_single_ack", DATA_W'(ack_cnt), DATA_W'(1));

        // Contention ordering from reset.
        do_reset();
        wr_req = 1; rd_req = 1; wr_addr = ADDR_W'('h40); rd_addr = ADDR_W'('h80);
        seq = '0; nseq = 0;
        for (int i = 0; i < 40 && nseq < 4; i++) begin
            step();
            if (obs_wr_ack || obs_rd_ack) begin
                seq = {seq[2:0], obs_wr_ack};
                nseq++;
            end
        end
        chk("rr_count", DATA_W'(nseq), DATA_W'(4));
`ifdef MIG_ARB_RD_PRIORITY_EN
        chk("grant_order", DATA_W'(seq), DATA_W'(4'b0000));
`else
        chk("grant_order", DATA_W'(seq), DATA_W'(4'b1010));
`endif
        wr_req = 0; rd_req = 0;
        step();

        // Outstanding-read limit.
        do_reset();
        rd_req = 1;
        ack_cnt = 0;
        repeat (80) begin
            step();
            ack_cnt += obs_rd_ack;
        end
        chk("rd_limit_acks", DATA_W'(ack_cnt), DATA_W'(MAX_RD_OUT));
        app_rd_data = rand256(); app_rd_data_valid = 1;
        step();
        app_rd_data_valid = 0;
        ack_cnt = 0;
        repeat (10) begin
            step();
            ack_cnt += obs_rd_ack;
        end
        chk("rd_after_return", DATA_W'(ack_cnt), DATA_W'(1));
        rd_req = 0;

        // Underflow is sticky until reset.
        do_reset();
        app_rd_data_valid = 1;
        step();
        app_rd_data_valid = 0;
        step();
        chk("underflow_set", DATA_W'(obs_err), DATA_W'(1));
        repeat (20) step();
        chk("underflow_sticky", DATA_W'(obs_err), DATA_W'(1));
        do_reset();
        chk("underflow_cleared", DATA_W'(obs_err), DATA_W'(0));

        // Reset in the middle of a stalled command.
        step();
        step();
        wr_req = 1; wr_addr = ADDR_W'('h300); app_rdy = 0;
        wait_en("midcmd_timeout");
        ui_clk_sync_rst = 1;
        step();
        ui_clk_sync_rst = 0; wr_req = 0; app_rdy = 1;
        step();
        chk("midcmd_en_dropped", DATA_W'(obs_en), DATA_W'(0));

        // Randomized traffic.
        mem_pend = 0; calib_lo = 0;
        for (int i = 0; i < 4000; i++) begin
            if (ui_clk_sync_rst) mem_pend = 0;
            else if (e_rd_ack) mem_pend++;
            if (!wr_req || e_wr_ack) begin
                wr_req = ($urandom_range(0, 2) != 0);
                wr_addr = ADDR_W'($urandom);
                wr_data = rand256();
            end
            if (!rd_req || e_rd_ack) begin
                rd_req = ($urandom_range(0, 2) != 0);
                rd_addr = ADDR_W'($urandom);
            end
            app_rdy = ($urandom_range(0, 3) != 0);
            app_wdf_rdy = ($urandom_range(0, 3) != 0);
            app_rd_data = rand256();
            if (mem_pend > 0 && $urandom_range(0, 2) == 0) begin
                app_rd_data_valid = 1;
                mem_pend--;
            end else begin
                app_rd_data_valid = (mem_pend == 0) && ($urandom_range(0, 399) == 0);
            end
            if (calib_lo > 0) begin
                init_calib_complete = 0;
                calib_lo--;
            end else begin
                init_calib_complete = 1;
                if ($urandom_range(0, 149) == 0) calib_lo = $urandom_range(1, 6);
            end
            ui_clk_sync_rst = ($urandom_range(0, 599) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
